// File: rtl/bias_store_pp.sv
// Ping-pong bias store: host loads the shadow bank while compute reads the
// active bank; an explicit swap exchanges them. Read latency is one cycle.
module bias_store_pp #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned BUS_W      = 128,
  parameter int unsigned MAX_GROUPS = 128,
  localparam int unsigned BEATS     = LANES * 32 / BUS_W,
  localparam int unsigned GRP_W     = $clog2(MAX_GROUPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_start,
  input  logic             wr_en,
  input  logic [BUS_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic             wr_commit,
  output logic             wr_ovf,
  output logic             shadow_ready,
  input  logic             swap,
  output logic             swap_err,
  output logic             active_bank,
  output logic [GRP_W:0]   active_groups,
  input  logic             rd_en,
  input  logic [GRP_W-1:0] rd_group,
  output logic [31:0]      bias_out [0:LANES-1],
  output logic             rd_valid,
  output logic             rd_oob
);

  localparam int unsigned WPB    = BUS_W / 32;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Reject geometries where a group does not split into whole beats
  generate
    if ((BUS_W % 32) != 0 || ((LANES * 32) % BUS_W) != 0 || BEATS < 1) begin : g_bad_cfg
      $error("bias_store_pp: LANES*32 must be a non-zero multiple of BUS_W, BUS_W a multiple of 32");
    end
  endgenerate

  logic [BUS_W-1:0] mem [0:1][0:BEATS-1][0:MAX_GROUPS-1];

  logic [GRP_W:0]   wr_grp;
  logic [BEAT_W-1:0] wr_beat;
  logic [GRP_W:0]   shadow_groups;

  logic             start_ok;
  logic             accept;
  logic             full;
  logic             wr_fire;
  logic             swap_ok;
  logic             oob;
  logic [GRP_W:0]   eff_grp;
  logic [BEAT_W-1:0] eff_beat;
  logic [31:0]      rd_word [0:LANES-1];

  // Effective write pointer: wr_start rewinds to zero in the same cycle
  always_comb begin
    start_ok = wr_start && !shadow_ready;
    eff_grp  = start_ok ? '0 : wr_grp;
    eff_beat = start_ok ? '0 : wr_beat;
    accept   = wr_en && wr_ready;
    full     = (eff_grp == (GRP_W+1)'(MAX_GROUPS));
    wr_fire  = accept && !full;
    swap_ok  = swap && shadow_ready;
    oob      = ({1'b0, rd_group} >= active_groups);
  end

  // Load / commit / swap control
  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank   <= 1'b0;
      active_groups <= '0;
      shadow_groups <= '0;
      shadow_ready  <= 1'b0;
      wr_ready      <= 1'b1;
      wr_grp        <= '0;
      wr_beat       <= '0;
      wr_ovf        <= 1'b0;
      swap_err      <= 1'b0;
    end else begin
      swap_err <= swap && !shadow_ready;
      wr_ovf   <= (start_ok ? 1'b0 : wr_ovf) | (accept && full);
      if (swap_ok) begin
        active_bank   <= ~active_bank;
        active_groups <= shadow_groups;
        shadow_groups <= active_groups;
        shadow_ready  <= 1'b0;
        wr_ready      <= 1'b1;
        wr_grp        <= '0;
        wr_beat       <= '0;
      end else begin
        if (wr_fire && eff_beat == BEAT_W'(BEATS - 1)) begin
          wr_grp  <= eff_grp + (GRP_W+1)'(1);
          wr_beat <= '0;
        end else if (wr_fire) begin
          wr_grp  <= eff_grp;
          wr_beat <= eff_beat + BEAT_W'(1);
        end else begin
          wr_grp  <= eff_grp;
          wr_beat <= eff_beat;
        end
        // Trailing partial-group beats are not counted
        if (wr_commit && !shadow_ready) begin
          shadow_groups <= eff_grp;
          shadow_ready  <= 1'b1;
          wr_ready      <= 1'b0;
        end
      end
    end
  end

  // Shadow bank write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem[~active_bank][eff_beat][eff_grp[GRP_W-1:0]] <= wr_data;
    end
  end

  // Lane l lives in beat l/WPB, word l%WPB
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign rd_word[l] = mem[active_bank][l / WPB][rd_group][32 * (l % WPB) +: 32];
    end
  endgenerate

  // Registered read; bias_out holds when idle, zero on out-of-range
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
      for (int i = 0; i < LANES; i++) bias_out[i] <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_oob   <= rd_en && oob;
      if (rd_en) begin
        for (int i = 0; i < LANES; i++) bias_out[i] <= oob ? 32'd0 : rd_word[i];
      end
    end
  end

endmodule

// File: tb/tb_bias_store_pp.sv
// Scoreboard bench for bias_store_pp: driver runs a flat-array reference
// model and queues the expected per-cycle outputs; a negedge monitor compares.
module tb_bias_store_pp;

  localparam int unsigned LANES = 8;
  localparam int unsigned BUS_W = 128;
  localparam int unsigned MAXG  = 4;
  localparam int unsigned GRP_W = $clog2(MAXG);
  localparam int unsigned WPB   = BUS_W / 32;
  localparam int unsigned BEATS = LANES / WPB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_start = 1'b0;
  logic             wr_en = 1'b0;
  logic [BUS_W-1:0] wr_data = '0;
  logic             wr_ready;
  logic             wr_commit = 1'b0;
  logic             wr_ovf;
  logic             shadow_ready;
  logic             swap = 1'b0;
  logic             swap_err;
  logic             active_bank;
  logic [GRP_W:0]   active_groups;
  logic             rd_en = 1'b0;
  logic [GRP_W-1:0] rd_group = '0;
  logic [31:0]      bias_out [0:LANES-1];
  logic             rd_valid;
  logic             rd_oob;

  bias_store_pp #(.LANES(LANES), .BUS_W(BUS_W), .MAX_GROUPS(MAXG)) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_commit(wr_commit), .wr_ovf(wr_ovf),
    .shadow_ready(shadow_ready), .swap(swap), .swap_err(swap_err),
    .active_bank(active_bank), .active_groups(active_groups), .rd_en(rd_en),
    .rd_group(rd_group), .bias_out(bias_out), .rd_valid(rd_valid), .rd_oob(rd_oob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 valid;
    logic                 oob;
    logic [LANES*32-1:0]  data;
    logic                 act;
    logic [GRP_W:0]       groups;
    logic                 sr;
    logic                 wrdy;
    logic                 ovf;
    logic                 serr;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: each bank is a flat list of biases; beat p carries
  // biases p*WPB .. p*WPB+WPB-1, group g is biases g*LANES .. g*LANES+LANES-1.
  logic [31:0]         m_mem [0:1][0:MAXG*LANES-1];
  int                  m_grp [0:1];
  int                  m_ptr;
  bit                  m_act, m_sr, m_ovf, m_serr;
  logic [LANES*32-1:0] m_hold;

  function automatic logic [BUS_W-1:0] mk_beat(input int base);
    logic [BUS_W-1:0] r;
    for (int i = 0; i < WPB; i++) r[i*32 +: 32] = 32'(base + i);
    return r;
  endfunction

  task automatic step(input bit r, input bit ws, input bit we, input logic [BUS_W-1:0] wd,
                      input bit wc, input bit sw, input bit re, input int rg);
    exp_t e;
    int   p;
    int   cnt;
    bit   sok;
    rst = r; wr_start = ws; wr_en = we; wr_data = wd;
    wr_commit = wc; swap = sw; rd_en = re; rd_group = GRP_W'(rg);
    e = '0;
    // Read result is decided by the bank active this cycle
    if (r) begin
      m_hold = '0;
    end else if (re) begin
      e.valid = 1'b1;
      if (rg >= m_grp[m_act]) begin
        e.oob  = 1'b1;
        m_hold = '0;
      end else begin
        for (int l = 0; l < LANES; l++) m_hold[l*32 +: 32] = m_mem[m_act][rg*LANES + l];
      end
    end
    e.data = m_hold;
    if (r) begin
      m_act = 0; m_grp[0] = 0; m_grp[1] = 0; m_ptr = 0; m_sr = 0; m_ovf = 0; m_serr = 0;
    end else begin
      m_serr = sw && !m_sr;
      sok    = ws && !m_sr;
      p      = sok ? 0 : m_ptr;
      if (sok) m_ovf = 0;
      cnt = p / BEATS;
      if (we && !m_sr) begin
        if (p < MAXG * BEATS) begin
          for (int i = 0; i < WPB; i++) m_mem[!m_act][p*WPB + i] = wd[i*32 +: 32];
          p++;
        end else begin
          m_ovf = 1;
        end
      end
      if (sw && m_sr) begin
        m_act = !m_act;
        m_sr  = 0;
        p     = 0;
      end else if (wc && !m_sr) begin
        m_grp[!m_act] = cnt;
        m_sr = 1;
      end
      m_ptr = p;
    end
    e.act    = m_act;
    e.groups = (GRP_W+1)'(m_grp[m_act]);
    e.sr     = m_sr;
    e.wrdy   = !m_sr;
    e.ovf    = m_ovf;
    e.serr   = m_serr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int g);
    step(0, 0, 0, '0, 0, 0, 1, g);
  endtask

  task automatic cmp(input string nm, input logic [LANES*32-1:0] got, input logic [LANES*32-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare every output
  exp_t                mon_e;
  logic [LANES*32-1:0] mon_data;
  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) mon_data[l*32 +: 32] = bias_out[l];
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp("rd_valid", LANES*32'(rd_valid), LANES*32'(mon_e.valid));
      if (mon_e.valid) cmp("rd_oob", LANES*32'(rd_oob), LANES*32'(mon_e.oob));
      cmp("bias_out", mon_data, mon_e.data);
      cmp("active_bank", LANES*32'(active_bank), LANES*32'(mon_e.act));
      cmp("active_groups", LANES*32'(active_groups), LANES*32'(mon_e.groups));
      cmp("shadow_ready", LANES*32'(shadow_ready), LANES*32'(mon_e.sr));
      cmp("wr_ready", LANES*32'(wr_ready), LANES*32'(mon_e.wrdy));
      cmp("wr_ovf", LANES*32'(wr_ovf), LANES*32'(mon_e.ovf));
      cmp("swap_err", LANES*32'(swap_err), LANES*32'(mon_e.serr));
    end else if (rd_valid === 1'b1) begin
      cmp("unexpected_rd_valid", LANES*32'(rd_valid), '0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_hold = '0;
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    idle(1);

    // Layer A: biases 0..15, two groups
    step(0, 1, 1, mk_beat(0), 0, 0, 0, 0);
    for (int b = 1; b < 4; b++) step(0, 0, 1, mk_beat(b*4), 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    rd(1); rd(2); rd(0); idle(2);

    // Layer B loaded while A is read continuously; swap coincides with a read
    step(0, 1, 1, mk_beat(100), 0, 0, 1, 0);
    for (int b = 1; b < 4; b++) step(0, 0, 1, mk_beat(100 + b*4), 0, 0, 1, b % 2);
    step(0, 0, 0, '0, 1, 0, 1, 1);
    step(0, 0, 0, '0, 0, 1, 1, 1);
    rd(1); rd(0); idle(1);

    // Swap without commit, then commit and swap together
    step(0, 0, 0, '0, 0, 1, 0, 0);
    idle(1);
    step(0, 1, 1, mk_beat(200), 0, 0, 0, 0);
    step(0, 0, 1, mk_beat(204), 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    rd(0); idle(1);

    // Overflow: 9 beats into a 4-group bank
    step(0, 1, 1, mk_beat(300), 0, 0, 0, 0);
    for (int b = 1; b < 9; b++) step(0, 0, 1, mk_beat(300 + b*4), 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    rd(3); idle(1);
    step(0, 1, 0, '0, 0, 0, 0, 0);
    idle(1);

    // Partial group: 3 beats commit as one group
    for (int b = 0; b < 3; b++) step(0, 0, 1, mk_beat(400 + b*4), 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    rd(0); rd(1); idle(1);

    // Reset in the middle of a load with a read in flight
    step(0, 1, 1, mk_beat(500), 0, 0, 1, 0);
    step(0, 0, 1, mk_beat(504), 0, 0, 1, 0);
    step(1, 0, 1, mk_beat(508), 0, 0, 1, 0);
    rd(0); idle(2);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 249) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 1),
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, MAXG - 1)));
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bias_store_pp.md
Name: bias_store_pp

Overview:
Double-buffered (ping-pong) bias store for the conv output stage. The host/DMA loads the next layer's biases into the shadow bank while the compute pipeline reads the current layer's biases from the active bank. An explicit swap handshake exchanges the two banks. Generalises the single-bank bias store to a configurable lane count, bus width and depth, and adds per-bank group counts, out-of-range detection and overflow detection.

Parameters:
LANES, 8, biases returned per read (one output-channel group)
BUS_W, 128, write beat width in bits; must be a multiple of 32
MAX_GROUPS, 128, max groups per bank
BEATS, LANES*32/BUS_W, derived: write beats per group; must be an integer >= 1 (elaboration error otherwise)
GRP_W, $clog2(MAX_GROUPS), derived: group index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_start  in  1  pulse: begin a new load into the shadow bank; clears the write pointer and wr_ovf
wr_en  in  1  write beat valid
wr_data  in  BUS_W  beat; 32-bit bias i at bits [32i +: 32]
wr_ready  out  1  shadow bank accepts beats (0 while shadow_ready=1)
wr_commit  in  1  pulse: load complete, marks the shadow bank loaded
wr_ovf  out  1  sticky: a beat was dropped because the shadow bank was full
shadow_ready  out  1  shadow bank committed and awaiting swap
swap  in  1  pulse: exchange active and shadow banks
swap_err  out  1  1-cycle pulse: swap requested with shadow_ready=0
active_bank  out  1  index of the bank currently read
active_groups  out  GRP_W+1  valid group count of the active bank
rd_en  in  1  read request
rd_group  in  GRP_W  group index within the active bank
bias_out  out  32 x LANES (unpacked [0:LANES-1])  biases of the group, lane l = beat l/(BUS_W/32), word l%(BUS_W/32)
rd_valid  out  1  bias_out valid
rd_oob  out  1  qualifies rd_valid: requested group >= active_groups; bias_out forced to 0

Behaviour:
- Storage: 2 banks, each BEATS arrays of MAX_GROUPS x BUS_W words. The write pointer splits into group = ptr/BEATS and beat = ptr%BEATS. Beat k of a group goes to array k.
- Reset: active_bank=0; both group counts=0; write pointer=0; shadow_ready=0; wr_ovf=0; swap_err=0; rd_valid=0; rd_oob=0; bias_out=0. Memory contents are not cleared.
- Write (to bank ~active_bank):
  - A beat is accepted when wr_en && wr_ready; the pointer increments.
  - When the pointer reaches MAX_GROUPS*BEATS, further accepted beats are dropped and wr_ovf=1 (sticky until wr_start or rst).
  - wr_en while wr_ready=0 is ignored and does not set wr_ovf.
  - wr_start with wr_en in the same cycle: the beat is written at pointer 0 and the pointer becomes 1.
  - wr_start while shadow_ready=1 is ignored.
- Commit:
  - wr_commit with shadow_ready=0: shadow group count = floor(ptr/BEATS), shadow_ready=1 next cycle, wr_ready=0.
  - Trailing partial-group beats are not counted.
  - wr_commit with shadow_ready=1 is ignored.
- Swap:
  - swap with shadow_ready=1: next cycle active_bank flips, active_groups takes the committed count, shadow_ready=0, write pointer=0, wr_ready=1.
  - swap with shadow_ready=0: no state change; swap_err pulses for 1 cycle.
  - swap and wr_commit in the same cycle: commit takes effect, swap is treated as not ready (swap_err pulses).
- Read, latency 1:
  - rd_en in cycle N gives rd_valid=1 in cycle N+1 with bias_out from the bank active in cycle N.
  - A swap in cycle N therefore does not affect the read issued in cycle N; reads from N+1 onward use the new bank.
  - rd_group >= active_groups: rd_oob=1 and bias_out=0.
  - Without rd_en, bias_out holds its last value and rd_valid=0.
  - Back-to-back rd_en every cycle is supported (throughput 1/cycle).
- Reads and writes are independent and concurrent (different banks). No read/write collision is possible.
- rst mid-load or mid-read: all control state returns to reset values the next cycle; any in-flight read result is discarded (rd_valid=0).

Test Plan:
- LANES=8, BUS_W=128: wr_start, 4 beats (bias values 0..15), wr_commit, swap -> active_bank=1, active_groups=2; rd_group=1 gives rd_valid one cycle later with bias_out=8..15 and rd_oob=0.
- Read with rd_group=2 after the load above -> rd_valid=1, rd_oob=1, bias_out all 0.
- While reading layer A continuously, load layer B (values 100..115) and commit, then swap in cycle N with rd_en in cycle N -> cycle N+1 returns A data; cycle N+2 returns B data.
- swap with no commit -> swap_err 1-cycle pulse, active_bank unchanged; wr_commit and swap in the same cycle -> shadow_ready=1, swap_err=1.
- MAX_GROUPS=4: write 9 beats -> the 9th is dropped, wr_ovf=1; commit -> group count 4; wr_start after swap clears wr_ovf.
- Commit with 3 beats (partial group) -> count 1; also assert rst mid-load -> shadow_ready=0, active_groups=0, rd_valid=0 next cycle.
